// File: rtl/axis_register_slice_if.sv
`default_nettype none
// ============================================================================
// axis_if : AXI4-Stream bundle with master (source) and slave (sink) views.
// Revision: 1.0
// ============================================================================
interface axis_if #(
  parameter int N = 2,
  parameter int I = 1,
  parameter int D = 1,
  parameter int U = 1
);
  logic           tvalid;
  logic           tready;
  logic [8*N-1:0] tdata;
  logic [N-1:0]   tstrb;
  logic [N-1:0]   tkeep;
  logic           tlast;
  logic [I-1:0]   tid;
  logic [D-1:0]   tdest;
  logic [U-1:0]   tuser;

  modport master (
    output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
    output tready
  );
endinterface
`default_nettype wire

// File: rtl/axis_register_slice.sv
`default_nettype none
// ============================================================================
// axis_register_slice : AXI4-Stream slice (wire-through, forward reg or skid).
// Revision: 1.0
// ============================================================================
module axis_register_slice #(
  parameter int N             = 2,
  parameter int I             = 1,
  parameter int D             = 1,
  parameter int U             = 1,
  parameter int MODE          = 2,
  parameter int CONNECT_TLAST = 1,
  parameter int CONNECT_TUSER = 1
) (
  input wire     aclk,
  input wire     aresetn,
  axis_if.slave  axis_in,
  axis_if.master axis_out
);
  localparam int PAY_W = 10*N + 1 + I + D + U;

  typedef enum logic [1:0] {S_EMPTY = 2'd0, S_BUSY = 2'd1, S_FULL = 2'd2} state_t;

  logic             in_last;
  logic [U-1:0]     in_user;
  logic [PAY_W-1:0] in_pay;
  logic [PAY_W-1:0] out_pay;
  logic [8*N-1:0]   out_data;
  logic [N-1:0]     out_strb;
  logic [N-1:0]     out_keep;
  logic             out_last;
  logic [I-1:0]     out_id;
  logic [D-1:0]     out_dest;
  logic [U-1:0]     out_user;

  // Disconnected fields enter the payload as constants so synthesis drops their storage.
  assign in_last = (CONNECT_TLAST != 0) ? axis_in.tlast : 1'b1;
  assign in_user = (CONNECT_TUSER != 0) ? axis_in.tuser : '0;
  assign in_pay  = {axis_in.tdata, axis_in.tstrb, axis_in.tkeep, in_last,
                    axis_in.tid, axis_in.tdest, in_user};

  assign {out_data, out_strb, out_keep, out_last, out_id, out_dest, out_user} = out_pay;
  assign axis_out.tdata = out_data;
  assign axis_out.tstrb = out_strb;
  assign axis_out.tkeep = out_keep;
  assign axis_out.tid   = out_id;
  assign axis_out.tdest = out_dest;
  assign axis_out.tlast = (CONNECT_TLAST != 0) ? out_last : 1'b1;
  assign axis_out.tuser = (CONNECT_TUSER != 0) ? out_user : '0;

  if (MODE == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst  = aclk ^ aresetn;
    assign out_pay         = in_pay;
    assign axis_out.tvalid = axis_in.tvalid;
    assign axis_in.tready  = axis_out.tready;
  end else if (MODE == 1) begin : g_fwd
    logic             valid_q, valid_d;
    logic [PAY_W-1:0] pay_q, pay_d;
    logic             in_xfer;

    assign axis_in.tready  = aresetn && (!valid_q || axis_out.tready);
    assign in_xfer         = axis_in.tvalid && axis_in.tready;
    assign axis_out.tvalid = valid_q;
    assign out_pay         = pay_q;

    always_comb begin
      valid_d = valid_q;
      pay_d   = pay_q;
      if (in_xfer) begin
        valid_d = 1'b1;
        pay_d   = in_pay;
      end else if (axis_out.tready) begin
        valid_d = 1'b0;
      end
    end

    always_ff @(posedge aclk) begin
      if (!aresetn) begin
        valid_q <= 1'b0;
        pay_q   <= '0;
      end else begin
        valid_q <= valid_d;
        pay_q   <= pay_d;
      end
    end
  end else begin : g_skid
    state_t           state_q, state_d;
    logic             ready_q, valid_q;
    logic [PAY_W-1:0] main_q, main_d, skid_q, skid_d;
    logic             in_xfer, out_xfer;

    assign in_xfer         = axis_in.tvalid && ready_q;
    assign out_xfer        = valid_q && axis_out.tready;
    assign axis_in.tready  = ready_q;
    assign axis_out.tvalid = valid_q;
    assign out_pay         = main_q;

    always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
        S_EMPTY: begin
          if (in_xfer) begin
            state_d = S_BUSY;
            main_d  = in_pay;
          end
        end
        S_BUSY: begin
          if (in_xfer && out_xfer) begin
            main_d = in_pay;
          end else if (in_xfer) begin
            state_d = S_FULL;
            skid_d  = in_pay;
          end else if (out_xfer) begin
            state_d = S_EMPTY;
          end
        end
        S_FULL: begin
          if (out_xfer) begin
            state_d = S_BUSY;
            main_d  = skid_q;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end

    // tready/tvalid are registered copies of the next-state decode.
    always_ff @(posedge aclk) begin
      if (!aresetn) begin
        state_q <= S_EMPTY;
        ready_q <= 1'b0;
        valid_q <= 1'b0;
        main_q  <= '0;
        skid_q  <= '0;
      end else begin
        state_q <= state_d;
        ready_q <= (state_d != S_FULL);
        valid_q <= (state_d != S_EMPTY);
        main_q  <= main_d;
        skid_q  <= skid_d;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_axis_register_slice.sv
`default_nettype none
// ============================================================================
// tb_axis_register_slice : scoreboard bench for MODE 0/1/2 and CONNECT_* = 0.
// Revision: 1.0
// ============================================================================
module tb_axis_register_slice;
  localparam int N  = 2;
  localparam int I  = 1;
  localparam int D  = 1;
  localparam int U  = 1;
  localparam int W  = 24;
  localparam int NB = 10000;

  typedef logic [W-1:0] pay_t;

  logic clk = 1'b0;
  logic aresetn;
  always #5 clk = ~clk;

  axis_if #(.N(N), .I(I), .D(D), .U(U)) in2(), out2(), in1(), out1(), in0(), out0(), inc(), outc();

  axis_register_slice #(.N(N), .I(I), .D(D), .U(U), .MODE(2)) dut2 (
    .aclk(clk), .aresetn(aresetn), .axis_in(in2), .axis_out(out2));
  axis_register_slice #(.N(N), .I(I), .D(D), .U(U), .MODE(1)) dut1 (
    .aclk(clk), .aresetn(aresetn), .axis_in(in1), .axis_out(out1));
  axis_register_slice #(.N(N), .I(I), .D(D), .U(U), .MODE(0)) dut0 (
    .aclk(clk), .aresetn(aresetn), .axis_in(in0), .axis_out(out0));
  axis_register_slice #(.N(N), .I(I), .D(D), .U(U), .MODE(2),
                        .CONNECT_TLAST(0), .CONNECT_TUSER(0)) dutc (
    .aclk(clk), .aresetn(aresetn), .axis_in(inc), .axis_out(outc));

  int   n_checks = 0;
  int   n_fail   = 0;
  pay_t q2[$], q1[$], q0[$], qc[$];

  function automatic pay_t pk(input logic [15:0] d, input logic [1:0] s, input logic [1:0] k,
                              input logic l, input logic id, input logic de, input logic us);
    return {d, s, k, l, id, de, us};
  endfunction

  function automatic pay_t gen_beat(input int n);
    logic [31:0] r;
    r = $urandom;
    return pk(r[15:0], r[17:16], r[19:18], (n % 7 == 6), r[20], r[21], r[22]);
  endfunction

  task automatic test_reset();
    in2.tvalid = 1'b1; in2.tdata = 16'hDEAD;
    in1.tvalid = 1'b1; in1.tdata = 16'hBEEF;
    aresetn = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      n_checks++;
      if (out2.tvalid !== 1'b0 || in2.tready !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_m2: tvalid=%b tready=%b, required 0/0", out2.tvalid, in2.tready);
      end
      n_checks++;
      if (out1.tvalid !== 1'b0 || in1.tready !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_m1: tvalid=%b tready=%b, required 0/0", out1.tvalid, in1.tready);
      end
    end
    in2.tvalid = 1'b0;
    in1.tvalid = 1'b0;
    aresetn    = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (in2.tready !== 1'b1 || out2.tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL release_m2: tready=%b tvalid=%b, required 1/0", in2.tready, out2.tvalid);
    end
    n_checks++;
    if (in1.tready !== 1'b1 || out1.tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL release_m1: tready=%b tvalid=%b, required 1/0", in1.tready, out1.tvalid);
    end
  endtask

  task automatic test_streaming();
    pay_t p;
    logic ev;
    out2.tready = 1'b1; out1.tready = 1'b1; out0.tready = 1'b1;
    for (int c = 0; c <= 16; c++) begin
      @(posedge clk); #1;
      p = pk(c[15:0], 2'b11, 2'b11, (c == 15), c[0], c[1], c[2]);
      {in2.tdata, in2.tstrb, in2.tkeep, in2.tlast, in2.tid, in2.tdest, in2.tuser} = p;
      {in1.tdata, in1.tstrb, in1.tkeep, in1.tlast, in1.tid, in1.tdest, in1.tuser} = p;
      {in0.tdata, in0.tstrb, in0.tkeep, in0.tlast, in0.tid, in0.tdest, in0.tuser} = p;
      in2.tvalid = (c < 16); in1.tvalid = (c < 16); in0.tvalid = (c < 16);
      @(negedge clk);
      if (in2.tvalid && in2.tready) q2.push_back(p);
      if (in1.tvalid && in1.tready) q1.push_back(p);
      if (in0.tvalid && in0.tready) q0.push_back(p);
      // zero latency on the wire-through, exactly one cycle on both registered modes
      ev = (c < 16);
      n_checks++;
      if (out0.tvalid !== ev) begin
        n_fail++;
        $display("FAIL stream_m0_valid c=%0d: got %b, required %b", c, out0.tvalid, ev);
      end else if (out0.tvalid && q0.size() > 0) begin
        p = q0.pop_front();
        n_checks++;
        if (pk(out0.tdata, out0.tstrb, out0.tkeep, out0.tlast, out0.tid, out0.tdest, out0.tuser) !== p) begin
          n_fail++;
          $display("FAIL stream_m0_data c=%0d: got %h, required %h", c, out0.tdata, p[23:8]);
        end
      end
      ev = (c >= 1);
      n_checks++;
      if (out1.tvalid !== ev) begin
        n_fail++;
        $display("FAIL stream_m1_valid c=%0d: got %b, required %b", c, out1.tvalid, ev);
      end else if (out1.tvalid && q1.size() > 0) begin
        p = q1.pop_front();
        n_checks++;
        if (pk(out1.tdata, out1.tstrb, out1.tkeep, out1.tlast, out1.tid, out1.tdest, out1.tuser) !== p) begin
          n_fail++;
          $display("FAIL stream_m1_data c=%0d: got %h, required %h", c, out1.tdata, p[23:8]);
        end
      end
      n_checks++;
      if (out2.tvalid !== ev) begin
        n_fail++;
        $display("FAIL stream_m2_valid c=%0d: got %b, required %b", c, out2.tvalid, ev);
      end else if (out2.tvalid && q2.size() > 0) begin
        p = q2.pop_front();
        n_checks++;
        if (pk(out2.tdata, out2.tstrb, out2.tkeep, out2.tlast, out2.tid, out2.tdest, out2.tuser) !== p) begin
          n_fail++;
          $display("FAIL stream_m2_data c=%0d: got %h, required %h", c, out2.tdata, p[23:8]);
        end
      end
    end
    n_checks++;
    if (q0.size() + q1.size() + q2.size() != 0) begin
      n_fail++;
      $display("FAIL stream_left: got %0d/%0d/%0d beats pending, required 0", q0.size(), q1.size(), q2.size());
    end
    q0.delete(); q1.delete(); q2.delete();
  endtask

  task automatic test_stall();
    logic [15:0] beats [3];
    logic        exp_v [8];
    logic [15:0] exp_d [8];
    logic        exp_r [8];
    int          idx;
    pay_t        p;
    beats = '{16'h00A1, 16'h00A2, 16'h00A3};
    exp_v = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_d = '{16'h0000, 16'h00A1, 16'h00A1, 16'h00A1, 16'h00A1, 16'h00A2, 16'h00A3, 16'h0000};
    exp_r = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      out2.tready = (c >= 4);
      in2.tvalid  = (idx < 3);
      if (idx < 3) begin
        p = pk(beats[idx], 2'b11, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        {in2.tdata, in2.tstrb, in2.tkeep, in2.tlast, in2.tid, in2.tdest, in2.tuser} = p;
      end
      @(negedge clk);
      n_checks++;
      if (out2.tvalid !== exp_v[c] || (exp_v[c] && out2.tdata !== exp_d[c])) begin
        n_fail++;
        $display("FAIL stall_out c=%0d: got v=%b d=%h, required v=%b d=%h",
                 c, out2.tvalid, out2.tdata, exp_v[c], exp_d[c]);
      end
      n_checks++;
      if (in2.tready !== exp_r[c]) begin
        n_fail++;
        $display("FAIL stall_ready c=%0d: got %b, required %b", c, in2.tready, exp_r[c]);
      end
      if (in2.tvalid && in2.tready) begin
        q2.push_back(p);
        idx++;
      end
      if (out2.tvalid && out2.tready) begin
        n_checks++;
        if (q2.size() == 0) begin
          n_fail++;
          $display("FAIL stall_sb c=%0d: got extra beat %h, required none", c, out2.tdata);
        end else begin
          p = q2.pop_front();
          if (pk(out2.tdata, out2.tstrb, out2.tkeep, out2.tlast, out2.tid, out2.tdest, out2.tuser) !== p) begin
            n_fail++;
            $display("FAIL stall_sb c=%0d: got %h, required %h", c, out2.tdata, p[23:8]);
          end
        end
      end
    end
    n_checks++;
    if (idx != 3 || q2.size() != 0) begin
      n_fail++;
      $display("FAIL stall_done: got sent=%0d pending=%0d, required 3/0", idx, q2.size());
    end
    q2.delete();
  endtask

  task automatic test_random();
    int   sent2, recv2, sent1, recv1, cyc;
    logic acc2, acc1, stall2, stall1;
    pay_t prev2, prev1, p, o;
    sent2 = 0; recv2 = 0; sent1 = 0; recv1 = 0; cyc = 0;
    acc2 = 1'b0; acc1 = 1'b0; stall2 = 1'b0; stall1 = 1'b0;
    prev2 = '0; prev1 = '0;
    in2.tvalid = 1'b0; in1.tvalid = 1'b0;
    while ((recv2 < NB || recv1 < NB) && cyc < 60000) begin
      @(posedge clk); #1;
      if (!(in2.tvalid && !acc2)) begin
        in2.tvalid = (sent2 < NB) && ($urandom_range(0, 1) == 1);
        p = gen_beat(sent2);
        {in2.tdata, in2.tstrb, in2.tkeep, in2.tlast, in2.tid, in2.tdest, in2.tuser} = p;
      end
      if (!(in1.tvalid && !acc1)) begin
        in1.tvalid = (sent1 < NB) && ($urandom_range(0, 1) == 1);
        p = gen_beat(sent1);
        {in1.tdata, in1.tstrb, in1.tkeep, in1.tlast, in1.tid, in1.tdest, in1.tuser} = p;
      end
      out2.tready = (sent2 >= NB) || ($urandom_range(0, 1) == 1);
      out1.tready = (sent1 >= NB) || ($urandom_range(0, 1) == 1);
      @(negedge clk);
      acc2 = in2.tvalid && in2.tready;
      acc1 = in1.tvalid && in1.tready;
      if (acc2) begin
        q2.push_back(pk(in2.tdata, in2.tstrb, in2.tkeep, in2.tlast, in2.tid, in2.tdest, in2.tuser));
        sent2++;
      end
      if (acc1) begin
        q1.push_back(pk(in1.tdata, in1.tstrb, in1.tkeep, in1.tlast, in1.tid, in1.tdest, in1.tuser));
        sent1++;
      end
      o = pk(out2.tdata, out2.tstrb, out2.tkeep, out2.tlast, out2.tid, out2.tdest, out2.tuser);
      if (stall2) begin
        n_checks++;
        if (out2.tvalid !== 1'b1 || o !== prev2) begin
          n_fail++;
          $display("FAIL rand_m2_stable cyc=%0d: got v=%b %h, required v=1 %h", cyc, out2.tvalid, o, prev2);
        end
      end
      if (out2.tvalid && out2.tready) begin
        n_checks++;
        recv2++;
        if (q2.size() == 0) begin
          n_fail++;
          $display("FAIL rand_m2_sb cyc=%0d: got extra beat %h, required none", cyc, o);
        end else begin
          p = q2.pop_front();
          if (o !== p) begin
            n_fail++;
            $display("FAIL rand_m2_sb cyc=%0d: got %h, required %h", cyc, o, p);
          end
        end
      end
      stall2 = out2.tvalid && !out2.tready;
      prev2  = o;
      o = pk(out1.tdata, out1.tstrb, out1.tkeep, out1.tlast, out1.tid, out1.tdest, out1.tuser);
      if (stall1) begin
        n_checks++;
        if (out1.tvalid !== 1'b1 || o !== prev1) begin
          n_fail++;
          $display("FAIL rand_m1_stable cyc=%0d: got v=%b %h, required v=1 %h", cyc, out1.tvalid, o, prev1);
        end
      end
      if (out1.tvalid && out1.tready) begin
        n_checks++;
        recv1++;
        if (q1.size() == 0) begin
          n_fail++;
          $display("FAIL rand_m1_sb cyc=%0d: got extra beat %h, required none", cyc, o);
        end else begin
          p = q1.pop_front();
          if (o !== p) begin
            n_fail++;
            $display("FAIL rand_m1_sb cyc=%0d: got %h, required %h", cyc, o, p);
          end
        end
      end
      stall1 = out1.tvalid && !out1.tready;
      prev1  = o;
      cyc++;
    end
    n_checks++;
    if (recv2 != NB || recv1 != NB || q2.size() != 0 || q1.size() != 0) begin
      n_fail++;
      $display("FAIL rand_done: got recv=%0d/%0d pending=%0d/%0d after %0d cycles, required %0d/%0d 0/0",
               recv2, recv1, q2.size(), q1.size(), cyc, NB, NB);
    end
    in2.tvalid = 1'b0; in1.tvalid = 1'b0;
    q2.delete(); q1.delete();
  endtask

  task automatic test_mid_reset();
    logic seen, acc;
    out2.tready = 1'b0;
    @(posedge clk); #1;
    in2.tvalid = 1'b1;
    {in2.tdata, in2.tstrb, in2.tkeep, in2.tlast, in2.tid, in2.tdest, in2.tuser} =
      pk(16'h00B1, 2'b11, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    in2.tdata = 16'h00B2;
    @(posedge clk); #1;
    in2.tvalid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in2.tready !== 1'b0 || out2.tvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL mreset_full: got tready=%b tvalid=%b, required 0/1", in2.tready, out2.tvalid);
    end
    @(posedge clk); #1;
    aresetn = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (in2.tready !== 1'b0 || out2.tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL mreset_clear: got tready=%b tvalid=%b, required 0/0", in2.tready, out2.tvalid);
    end
    aresetn     = 1'b1;
    out2.tready = 1'b1;
    in2.tvalid  = 1'b1;
    in2.tdata   = 16'h0055;
    seen = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      @(negedge clk);
      acc = in2.tvalid && in2.tready;
      if (out2.tvalid && out2.tready) begin
        seen = 1'b1;
        n_checks++;
        if (out2.tdata !== 16'h0055) begin
          n_fail++;
          $display("FAIL mreset_first: got %h, required 0055", out2.tdata);
        end
      end
      @(posedge clk); #1;
      if (acc) in2.tvalid = 1'b0;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL mreset_timeout: got no output beat, required 0055");
    end
    in2.tvalid = 1'b0;
  endtask

  task automatic test_connect();
    int   idx, seen;
    pay_t p;
    outc.tready = 1'b1;
    idx  = 0;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      inc.tvalid = (idx < 4);
      {inc.tdata, inc.tstrb, inc.tkeep, inc.tlast, inc.tid, inc.tdest, inc.tuser} =
        pk(16'h00C0 + idx[15:0], 2'b11, 2'b01, 1'b0, idx[0], idx[1], 1'b1);
      @(negedge clk);
      if (inc.tvalid && inc.tready) begin
        qc.push_back(pk(inc.tdata, inc.tstrb, inc.tkeep, 1'b1, inc.tid, inc.tdest, 1'b0));
        idx++;
      end
      if (outc.tvalid && outc.tready) begin
        seen++;
        n_checks++;
        if (qc.size() == 0) begin
          n_fail++;
          $display("FAIL connect_sb: got extra beat %h, required none", outc.tdata);
        end else begin
          p = qc.pop_front();
          if (pk(outc.tdata, outc.tstrb, outc.tkeep, outc.tlast, outc.tid, outc.tdest, outc.tuser) !== p) begin
            n_fail++;
            $display("FAIL connect_beat: got d=%h last=%b user=%b, required d=%h last=1 user=0",
                     outc.tdata, outc.tlast, outc.tuser, p[23:8]);
          end
        end
      end
    end
    n_checks++;
    if (seen != 4) begin
      n_fail++;
      $display("FAIL connect_count: got %0d beats, required 4", seen);
    end
    inc.tvalid = 1'b0;
  endtask

  initial begin
    aresetn = 1'b0;
    {in2.tvalid, in2.tdata, in2.tstrb, in2.tkeep, in2.tlast, in2.tid, in2.tdest, in2.tuser} = '0;
    {in1.tvalid, in1.tdata, in1.tstrb, in1.tkeep, in1.tlast, in1.tid, in1.tdest, in1.tuser} = '0;
    {in0.tvalid, in0.tdata, in0.tstrb, in0.tkeep, in0.tlast, in0.tid, in0.tdest, in0.tuser} = '0;
    {inc.tvalid, inc.tdata, inc.tstrb, inc.tkeep, inc.tlast, inc.tid, inc.tdest, inc.tuser} = '0;
    out2.tready = 1'b0; out1.tready = 1'b0; out0.tready = 1'b0; outc.tready = 1'b0;
    test_reset();
    test_streaming();
    test_stall();
    test_random();
    test_mid_reset();
    test_connect();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
